// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared types and sizing helper for the async FIFO write-side arbiter and its schedulers
package async_fifo_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/async_fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set req after last_id_i, wrapping modulo N
//   req_i     request vector
//   last_id_i index granted last time (lowest priority now)
//   any_o     at least one request set
//   pick_o    winning index (meaningful when any_o)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_id_i,
  output logic          any_o,
  output logic [IW-1:0] pick_o
);
  int start;
  int off;
  logic [N-1:0] rot;
  always_comb begin
    start = (int'(last_id_i) + 1) % N;
    for (int i = 0; i < N; i++) rot[i] = req_i[(start + i) % N];
    off = 0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = i;
    any_o = |req_i;
    pick_o = IW'((start + off) % N);
  end
endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// async_fifo_wr_arbiter: round-robin burst-locked arbiter sharing the FIFO write port among NUM_REQ producers
//   wclk, wrst        write clock, synchronous active-high reset
//   arb_en            allow new grants (a running burst always completes)
//   req_valid/last    per-producer valid and end-of-burst marker
//   req_data          producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         accept strobe, at most one bit high
//   wfull             FIFO full; stalls the burst
//   winc, wdata       FIFO write enable and data
//   gnt_valid, gnt_id burst in progress and its owner
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          gnt_valid,
  output logic [idx_w(NUM_REQ)-1:0]     gnt_id
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  arb_state_t state_q, state_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d, last_id_q, last_id_d, pick;
  logic [CW-1:0] beat_q, beat_d;
  logic any, v, beat, done;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i(req_valid),
    .last_id_i(last_id_q),
    .any_o(any),
    .pick_o(pick)
  );
  assign v = req_valid[gnt_id_q];
  assign beat = (state_q == ARB_BURST) && v && !wfull;
  assign done = req_last[gnt_id_q] || (beat_q == LAST_BEAT);
  // last_id resets to NUM_REQ-1 so requester 0 holds top priority after reset
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q   <= ARB_IDLE;
      gnt_id_q  <= '0;
      last_id_q <= IW'(NUM_REQ - 1);
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      beat_q    <= beat_d;
    end
  end
  // a stall (wfull with valid high) falls through every branch and holds the beat count
  always_comb begin
    state_d = state_q;
    gnt_id_d = gnt_id_q;
    last_id_d = last_id_q;
    beat_d = beat_q;
    if (state_q == ARB_IDLE) begin
      if (arb_en && any) begin
        state_d = ARB_BURST;
        gnt_id_d = pick;
        last_id_d = pick;
        beat_d = '0;
      end
    end else if (beat) begin
      state_d = done ? ARB_IDLE : ARB_BURST;
      beat_d = done ? '0 : beat_q + 1'b1;
    end else if (!v) begin
      state_d = ARB_IDLE;
      beat_d = '0;
    end
  end
  always_comb begin
    winc = beat;
    req_ready = beat ? (NUM_REQ'(1) << gnt_id_q) : '0;
    wdata = req_data[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
    gnt_valid = state_q == ARB_BURST;
    gnt_id = gnt_id_q;
  end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb_async_fifo_wr_arbiter: directed self-checking bench for the write-port arbiter
module tb_async_fifo_wr_arbiter;
  logic wclk = 1'b0;
  logic wrst, arb_en, wfull, winc, gnt_valid;
  logic [3:0] req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0] wdata;
  logic [1:0] gnt_id;
  int vecs = 0;
  int errs = 0;
  always #5 wclk = ~wclk;
  async_fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(8)) dut (
    .wclk(wclk),
    .wrst(wrst),
    .arb_en(arb_en),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .wfull(wfull),
    .winc(winc),
    .wdata(wdata),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id)
  );
  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_cyc(input string tag, input logic gv, input logic [1:0] id, input logic w,
                         input logic [3:0] rdy, input logic [7:0] d, input bit cd);
    #1;
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(gv));
    if (gv) chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
    chk({tag, ".winc"}, 32'(winc), 32'(w));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    if (cd) chk({tag, ".wdata"}, 32'(wdata), 32'(d));
  endtask
  task automatic idle_chk(input string tag);
    chk_cyc(tag, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
  endtask
  task automatic beat_chk(input string tag, input int g);
    chk_cyc(tag, 1'b1, 2'(g), 1'b1, 4'(1 << g), 8'(8'hC0 + g), 1'b1);
  endtask
  initial begin
    wrst = 1'b1;
    arb_en = 1'b1;
    wfull = 1'b0;
    req_valid = 4'b0000;
    req_last = 4'b0000;
    req_data = 32'hC3C2C1C0;
    cyc();
    cyc();
    chk_cyc("reset", 1'b0, 2'd0, 1'b0, 4'b0000, 8'hC0, 1'b1);
    chk("reset.gnt_id", 32'(gnt_id), 32'd0);
    // single producer, 3-word burst ended by last
    wrst = 1'b0;
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA0;
    chk_cyc("t1.bubble", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    cyc();
    chk_cyc("t1.b0", 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA0, 1'b1);
    cyc();
    req_data[7:0] = 8'hA1;
    chk_cyc("t1.b1", 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA1, 1'b1);
    cyc();
    req_data[7:0] = 8'hA2;
    req_last = 4'b0001;
    chk_cyc("t1.b2", 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA2, 1'b1);
    cyc();
    req_valid = 4'b0000;
    req_last = 4'b0000;
    req_data[7:0] = 8'hC0;
    idle_chk("t1.end");
    cyc();
    // all requesting: cyclic order 1,2,3,0,1 with 8 beats each
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      idle_chk("t2.bubble");
      cyc();
      for (int b = 0; b < 8; b++) begin
        beat_chk("t2.beat", (1 + k) % 4);
        cyc();
      end
    end
    // requester 2: 3 beats, 5 stalled cycles, 5 more beats
    idle_chk("t3.bubble");
    cyc();
    for (int b = 0; b < 3; b++) begin
      beat_chk("t3.pre", 2);
      cyc();
    end
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      chk_cyc("t3.stall", 1'b1, 2'd2, 1'b0, 4'b0000, 8'h00, 1'b0);
      cyc();
    end
    wfull = 1'b0;
    for (int b = 0; b < 5; b++) begin
      beat_chk("t3.post", 2);
      cyc();
    end
    idle_chk("t3.end");
    cyc();
    // requester 3 drops valid after 2 beats
    for (int b = 0; b < 2; b++) begin
      beat_chk("t4.pre", 3);
      cyc();
    end
    req_valid = 4'b0111;
    chk_cyc("t4.drop", 1'b1, 2'd3, 1'b0, 4'b0000, 8'h00, 1'b0);
    cyc();
    idle_chk("t4.bubble0");
    cyc();
    for (int b = 0; b < 8; b++) begin
      beat_chk("t4.g0", 0);
      cyc();
    end
    req_valid = 4'b1000;
    idle_chk("t4.bubble3");
    cyc();
    for (int b = 0; b < 8; b++) begin
      beat_chk("t4.g3", 3);
      cyc();
    end
    // arb_en dropped during requester 2's burst
    req_valid = 4'b0100;
    idle_chk("t5.bubble");
    cyc();
    req_valid = 4'b1111;
    beat_chk("t5.b0", 2);
    cyc();
    arb_en = 1'b0;
    for (int b = 1; b < 8; b++) begin
      beat_chk("t5.beat", 2);
      cyc();
    end
    for (int s = 0; s < 3; s++) begin
      idle_chk("t5.disabled");
      cyc();
    end
    arb_en = 1'b1;
    idle_chk("t5.reenable");
    cyc();
    req_last = 4'b1000;
    beat_chk("t5.g3", 3);
    cyc();
    req_last = 4'b0000;
    // reset mid-burst of requester 0
    idle_chk("t6.bubble");
    cyc();
    beat_chk("t6.b0", 0);
    cyc();
    beat_chk("t6.b1", 0);
    cyc();
    wrst = 1'b1;
    beat_chk("t6.b2", 0);
    cyc();
    wrst = 1'b0;
    idle_chk("t6.reset");
    chk("t6.gnt_id", 32'(gnt_id), 32'd0);
    cyc();
    beat_chk("t6.regrant", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
